// File: rtl/add_sched_pkg.sv
// add_sched_pkg -- shared widths and the result record used by add_sched and its FIFO.
package add_sched_pkg;

    localparam int OP_W  = 16;
    localparam int SUM_W = OP_W + 1;
    localparam int N_REQ = 2;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic             tag;
    } res_t;

endpackage

// File: rtl/add_sched_fifo.sv
// add_sched_fifo -- first-word-fall-through result FIFO; pointers wrap modulo DEPTH,
// pop while empty is ignored.
module add_sched_fifo
    import add_sched_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  res_t             push_data,
    input  logic             pop,
    output res_t             pop_data,
    output logic [CNT_W-1:0] count
);

    res_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && (count_q != CNT_W'(DEPTH));
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop)
            count_d = count_q + 1'b1;
        else if (do_pop && !do_push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; an empty count already hides stale entries.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/add_sched.sv
// add_sched -- round-robin, credit-limited issue of two requesters onto a fixed-latency adder.
// req_a/req_b pack requester i in bits [16*i +: 16]. Define ADD_SCHED_STATS_EN for grant counters.
module add_sched
    import add_sched_pkg::*;
#(
    parameter int LAT   = 4,
    parameter int DEPTH = LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*OP_W-1:0] req_a,
    input  logic [N_REQ*OP_W-1:0] req_b,
    output logic                  add_vld,
    output logic [OP_W-1:0]       add_a,
    output logic [OP_W-1:0]       add_b,
    input  logic [SUM_W-1:0]      add_sum,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [SUM_W-1:0]      res_sum,
    output logic                  res_tag
`ifdef ADD_SCHED_STATS_EN
    ,
    output logic [15:0]           stat_grant0,
    output logic [15:0]           stat_grant1
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             last_q, last_d;
    logic [CNT_W-1:0] cred_q, cred_d;
    logic [LAT-1:0]   vld_q, vld_d;
    logic [LAT-1:0]   tag_q, tag_d;
    logic             grant, issue, pop;
    logic [CNT_W-1:0] fifo_count;
    res_t             fifo_wr, fifo_rd;

    // NOTE: req_ready gets its all-zero default before the indexed write so no latch is inferred.
    always_comb begin
        grant     = (&req_valid) ? ~last_q : req_valid[1];
        req_ready = '0;
        if (rst_n && (|req_valid) && (cred_q != '0))
            req_ready[grant] = 1'b1;
        issue   = |(req_valid & req_ready);
        add_vld = issue;
        add_a   = '0;
        add_b   = '0;
        if (issue) begin
            add_a = grant ? req_a[2*OP_W-1:OP_W] : req_a[OP_W-1:0];
            add_b = grant ? req_b[2*OP_W-1:OP_W] : req_b[OP_W-1:0];
        end

        res_valid = (fifo_count != '0);
        res_sum   = fifo_rd.sum;
        res_tag   = fifo_rd.tag;
        pop       = res_valid && res_ready;

        last_d = issue ? grant : last_q;
        cred_d = cred_q;
        if (issue && !pop)
            cred_d = cred_q - 1'b1;
        else if (pop && !issue)
            cred_d = cred_q + 1'b1;

        // The valid/tag pipe mirrors the adder so the sum is captured exactly LAT cycles after issue.
        vld_d    = vld_q << 1;
        vld_d[0] = issue;
        tag_d    = tag_q << 1;
        tag_d[0] = grant;

        fifo_wr.sum = add_sum;
        fifo_wr.tag = tag_q[LAT-1];
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
            cred_q <= CNT_W'(DEPTH);
            vld_q  <= '0;
            tag_q  <= '0;
        end else begin
            last_q <= last_d;
            cred_q <= cred_d;
            vld_q  <= vld_d;
            tag_q  <= tag_d;
        end
    end

    add_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_q[LAT-1]),
        .push_data (fifo_wr),
        .pop       (pop),
        .pop_data  (fifo_rd),
        .count     (fifo_count)
    );

`ifdef ADD_SCHED_STATS_EN
    logic [15:0] stat_grant0_q, stat_grant0_d;
    logic [15:0] stat_grant1_q, stat_grant1_d;

    always_comb begin
        stat_grant0_d = stat_grant0_q + 16'(req_valid[0] & req_ready[0]);
        stat_grant1_d = stat_grant1_q + 16'(req_valid[1] & req_ready[1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grant0_q <= '0;
            stat_grant1_q <= '0;
        end else begin
            stat_grant0_q <= stat_grant0_d;
            stat_grant1_q <= stat_grant1_d;
        end
    end

    assign stat_grant0 = stat_grant0_q;
    assign stat_grant1 = stat_grant1_q;
`endif

endmodule

// File: tb/tb_add_sched.sv
// tb_add_sched -- self-checking bench for add_sched against a queue-based reference model;
// with ADD_SCHED_STATS_EN it also checks the grant counters.
module tb_add_sched;
    import add_sched_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [15:0]       opa [2];
    logic [15:0]       opb [2];
    logic [31:0]       req_a, req_b;
    logic              add_vld;
    logic [15:0]       add_a, add_b;
    logic [16:0]       add_sum;
    logic              res_valid, res_ready, res_tag;
    logic [16:0]       res_sum;
`ifdef ADD_SCHED_STATS_EN
    logic [15:0]       stat_grant0, stat_grant1;
`endif

    always #5 clk = ~clk;

    assign req_a = {opa[1], opa[0]};
    assign req_b = {opb[1], opb[0]};

    add_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_vld   (add_vld),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_tag   (res_tag)
`ifdef ADD_SCHED_STATS_EN
        ,
        .stat_grant0 (stat_grant0),
        .stat_grant1 (stat_grant1)
`endif
    );

    // Behavioural LAT-cycle adder; it never resets, so sums issued before a reset still come back.
    logic [16:0] pipe [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= add_vld ? (17'(add_a) + 17'(add_b)) : 17'($urandom);
    end
    assign add_sum = pipe[LAT-1];

    typedef struct {
        logic [16:0] sum;
        logic        tag;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc, credits, last_g, sg0, sg1;
    int   n_checks, n_fail, n_xfer, n_rv;
    logic obs_rv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        credits = DEPTH;
        last_g  = 1;
        sg0     = 0;
        sg1     = 0;
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        int          g;
        logic [1:0]  er;
        logic        ei, erv;
        logic [15:0] ea, eb;
        @(negedge clk);
        if (!rst_n) model_reset();
        g   = (req_valid == 2'b11) ? 1 - last_g : (req_valid[1] ? 1 : 0);
        er  = (rst_n && req_valid != 2'b00 && credits > 0) ? 2'(1 << g) : 2'b00;
        ei  = (er != 2'b00);
        ea  = ei ? opa[g] : 16'h0;
        eb  = ei ? opb[g] : 16'h0;
        erv = (q.size() > 0) && (q[0].due <= cyc);
        chk("req_ready", req_ready, er);
        chk("add_vld", add_vld, ei);
        chk("add_a", add_a, ea);
        chk("add_b", add_b, eb);
        chk("res_valid", res_valid, erv);
        if (erv) begin
            chk("res_sum", res_sum, q[0].sum);
            chk("res_tag", res_tag, q[0].tag);
        end
`ifdef ADD_SCHED_STATS_EN
        chk("stat_grant0", stat_grant0, 16'(sg0));
        chk("stat_grant1", stat_grant1, 16'(sg1));
`endif
        obs_rv = res_valid;
        if ((req_valid & req_ready) != 2'b00) n_xfer++;
        if (res_valid) n_rv++;
        @(posedge clk);
        if (rst_n) begin
            if (ei) begin
                q.push_back('{sum: 17'(opa[g]) + 17'(opb[g]), tag: g[0], due: cyc + LAT + 1});
                last_g = g;
                credits--;
                if (g == 0) sg0++; else sg1++;
            end
            if (erv && res_ready) begin
                void'(q.pop_front());
                credits++;
            end
        end else begin
            model_reset();
        end
        cyc++;
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 2; i++) begin
            opa[i] = 16'($urandom);
            opb[i] = 16'($urandom);
        end
    endtask

`ifdef ADD_SCHED_STATS_EN
    logic [1:0]  s_req_valid, s_req_ready;
    logic        s_add_vld, s_res_valid, s_res_tag;
    logic [15:0] s_add_a, s_add_b, s_grant0, s_grant1;
    logic [16:0] s_res_sum;
    int          s_cnt;

    // Enough credits (LAT + 2) for one issue per cycle, so the long grant count stays short.
    add_sched #(.LAT(LAT), .DEPTH(LAT + 2)) u_stat (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (s_req_valid),
        .req_ready   (s_req_ready),
        .req_a       (32'h0001_0002),
        .req_b       (32'h0003_0004),
        .add_vld     (s_add_vld),
        .add_a       (s_add_a),
        .add_b       (s_add_b),
        .add_sum     (17'h0),
        .res_valid   (s_res_valid),
        .res_ready   (1'b1),
        .res_sum     (s_res_sum),
        .res_tag     (s_res_tag),
        .stat_grant0 (s_grant0),
        .stat_grant1 (s_grant1)
    );
`endif

    initial begin
        int first_rv;
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        res_ready = 1'b1;
        opa[0] = '0; opa[1] = '0; opb[0] = '0; opb[1] = '0;
`ifdef ADD_SCHED_STATS_EN
        s_req_valid = 2'b00;
`endif
        model_reset();

        // Outputs held low while reset is asserted.
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Single requester-0 add: 0x0001 + 0xFFFF, result five cycles after issue.
        req_valid = 2'b01;
        opa[0]    = 16'h0001;
        opb[0]    = 16'hFFFF;
        tick();
        req_valid = 2'b00;
        first_rv  = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (obs_rv && first_rv < 0) first_rv = i;
        end
        chk("first_result_cycle", 32'(first_rv), 32'd5);

        // Both requesters always valid with the consumer always ready.
        req_valid = 2'b11;
        for (int i = 0; i < 24; i++) begin
            rand_ops();
            tick();
        end

        // Random traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            req_valid = 2'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Drain.
        req_valid = 2'b00;
        res_ready = 1'b1;
        repeat (12) tick();

        // Reset in the middle of three issues: nothing from them may ever come out.
        req_valid = 2'b01;
        rand_ops();
        tick();
        rand_ops();
        tick();
        rst_n = 1'b0;
        rand_ops();
        tick();
        rst_n     = 1'b1;
        req_valid = 2'b00;
        n_rv      = 0;
        repeat (10) tick();
        chk("results_after_reset", 32'(n_rv), 32'd0);

        // Consumer stalled: exactly DEPTH transfers, then one more after a single pop.
        res_ready = 1'b0;
        req_valid = 2'b11;
        n_xfer    = 0;
        for (int i = 0; i < 10; i++) begin
            rand_ops();
            tick();
        end
        chk("stalled_transfers", 32'(n_xfer), 32'(DEPTH));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        repeat (6) tick();
        chk("transfers_after_pop", 32'(n_xfer), 32'(DEPTH + 1));

        req_valid = 2'b00;
        res_ready = 1'b1;
        repeat (12) tick();

`ifdef ADD_SCHED_STATS_EN
        // 0x10001 requester-1 grants wrap the counter to 1.
        s_req_valid = 2'b10;
        s_cnt       = 0;
        for (int i = 0; i < 80000 && s_cnt < 32'h10001; i++) begin
            @(negedge clk);
            if (s_req_valid[1] && s_req_ready[1]) s_cnt++;
            @(posedge clk);
        end
        #1 s_req_valid = 2'b00;
        chk("stat_run_grants", 32'(s_cnt), 32'h10001);
        @(negedge clk);
        chk("stat_grant1_wrap", s_grant1, 16'h0001);
        chk("stat_grant0_idle", s_grant0, 16'h0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/add_sched.md
ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 SHALL have parameter LAT, default 4, fixed latency of the pipelined 16-bit adder in cycles (legal 1..8).
REQ-002 SHALL have parameter DEPTH, default LAT, result-FIFO entries and issue credits (legal DEPTH >= LAT).
REQ-003 clk  input  1  single clock, all flops rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  2  per-requester operand valid (bit i = requester i).
REQ-006 req_ready  output  2  per-requester accept.
REQ-007 req_a, req_b  input  2x16  per-requester operands.
REQ-008 add_vld  output  1  issue strobe to adder.
REQ-009 add_a, add_b  output  16  operands to adder.
REQ-010 add_sum  input  17  adder result, carry-out in bit 16, valid LAT cycles after issue.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  consumer accept.
REQ-013 res_sum  output  17  result; res_tag  output  1  originating requester.

Function
REQ-014 Transfer on requester i SHALL occur when req_valid[i] and req_ready[i] are both high in a cycle.
REQ-015 req_ready[i] SHALL be combinational: high only if i is granted and credits > 0; at most one bit high.
REQ-016 Arbitration SHALL be round-robin: single valid requester granted; both valid -> requester not granted last; pointer updates only on a transfer.
REQ-017 On transfer in cycle T, add_vld SHALL be high in T with add_a/add_b equal to the granted operands (combinational); otherwise add_vld low, add_a/add_b 0.
REQ-018 A LAT-stage valid/tag shift register SHALL track in-flight issues; at cycle T+LAT add_sum SHALL be written to the FIFO with that tag.
REQ-019 FIFO SHALL be first-word-fall-through: res_valid high from cycle T+LAT+1 with an empty FIFO; order preserved strictly by issue.
REQ-020 Credit counter SHALL start at DEPTH, decrement on issue, increment on FIFO pop (res_valid & res_ready), unchanged on simultaneous issue and pop.
REQ-021 Credits = 0 SHALL force req_ready = 0; FIFO overflow SHALL be impossible by construction; pop with FIFO empty SHALL be ignored.
REQ-022 res_ready low SHALL hold res_sum/res_tag stable until popped.
REQ-023 FIFO and credit pointers SHALL wrap modulo DEPTH without bubbles; full-rate issue and pop SHALL sustain one result per cycle.

Reset
REQ-024 rst_n low SHALL clear shift-register valids, FIFO (empty), pointer (requester 0 wins first tie), credits = DEPTH; res_valid, add_vld, req_ready low while asserted.
REQ-025 Reset mid-operation SHALL discard all in-flight and buffered results; add_sum returning afterwards SHALL be ignored.

Configuration
REQ-026 Macro ADD_SCHED_STATS_EN defined: ports stat_grant0, stat_grant1 (output, 16 each) SHALL count transfers per requester, wrap at 0xFFFF->0, clear on reset.
REQ-027 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-028 Package add_sched_pkg SHALL hold operand width (16), sum width (17), requester count (2) and the result record type (sum + tag).
REQ-029 FIFO SHALL be sub-module add_sched_fifo (parameterized DEPTH, FWFT, count output).

Verification
REQ-030 Single req0 a=0x0001 b=0xFFFF, LAT=4 -> add_vld cycle 0; res_valid cycle 5, res_sum=0x10000, res_tag=0.
REQ-031 Both valid every cycle, res_ready=1 -> grants alternate 0,1,0,1; results in issue order, no gaps after first.
REQ-032 res_ready=0, continuous requests -> exactly DEPTH=4 transfers, then req_ready=0; one pop -> exactly one further transfer.
REQ-033 Issue 3 ops, assert rst_n low at cycle 2 for 1 cycle -> no res_valid ever for those ops; credits=4 after.
REQ-034 With ADD_SCHED_STATS_EN, 0x10001 req1 grants -> stat_grant1=0x0001, stat_grant0=0.
